// File: rtl/sc_seq_counter.sv
// sc_seq_counter: multi-pass bitstream position counter with IDLE/RUN/DONE sequencing.
// Optional feature: define SC_SEQ_ABORT_EN to let abort_i cancel a running sequence.
`ifndef SC_LEN_LOG
`define SC_LEN_LOG 8
`endif
module sc_seq_counter #(
    parameter int CNT_W  = `SC_LEN_LOG,
    parameter int PASS_W = 4
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_m1_i,
    input  logic [PASS_W-1:0] passes_m1_i,
    input  logic              enable_i,
    input  logic              abort_i,
    output logic [CNT_W-1:0]  sc_count_o,
    output logic [PASS_W-1:0] pass_idx_o,
    output logic              sc_count_done_o,
    output logic              pass_done_o,
    output logic              busy_o,
    output logic              done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q, len_q;
    logic [PASS_W-1:0] pass_q, passes_q;
    logic              last, abort_hit;
`ifdef SC_SEQ_ABORT_EN
    assign abort_hit = abort_i;
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign abort_hit    = 1'b0;
`endif
    assign last            = (state_q == RUN) && (cnt_q == len_q);
    assign sc_count_o      = cnt_q;
    assign pass_idx_o      = pass_q;
    assign sc_count_done_o = last;
    assign pass_done_o     = last && enable_i;
    assign busy_o          = state_q == RUN;
    assign done_o          = state_q == DONE;
    // Sequencer: start latches geometry, RUN walks positions then passes, DONE lasts one cycle.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pass_q   <= '0;
            len_q    <= '0;
            passes_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (abort_hit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        pass_q  <= '0;
                    end else if (enable_i) begin
                        if (cnt_q == len_q) begin
                            cnt_q <= '0;
                            if (pass_q < passes_q) begin
                                pass_q <= pass_q + 1'b1;
                            end else begin
                                pass_q  <= '0;
                                state_q <= DONE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        pass_q   <= '0;
                        len_q    <= len_m1_i;
                        passes_q <= passes_m1_i;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
